// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: register scoreboard with same-cycle
// writeback bypass, RAW/WAW stall detection, an IO drain/grant handshake
// that takes ownership of the register file, and a saturating stall counter.
module decode_hazard_ctrl #(
    parameter int ADDRESSWIDTH = 4,
    parameter int REGNUM       = 16,
    parameter int OPCODEWIDTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    decValid,
    input  logic [OPCODEWIDTH-1:0]  opcode,
    input  logic [ADDRESSWIDTH-1:0] reg1Address,
    input  logic [ADDRESSWIDTH-1:0] reg2Address,
    input  logic [ADDRESSWIDTH-1:0] regDestinationAddress,
    input  logic                    wbValid,
    input  logic [ADDRESSWIDTH-1:0] wbAddress,
    input  logic                    startIO,
    input  logic                    ioDone,
    output logic                    issue,
    output logic                    stall,
    output logic                    ioGrant,
    output logic [15:0]             stallCount
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_IO    = 2'd2;

    localparam logic [OPCODEWIDTH-1:0] OP_NOP   = OPCODEWIDTH'(4'hF);
    localparam logic [OPCODEWIDTH-1:0] OP_STORE = OPCODEWIDTH'(4'hE);
    localparam logic [OPCODEWIDTH-1:0] OP_IMM   = OPCODEWIDTH'(4'h8);

    logic [1:0]        r_state;
    logic [REGNUM-1:0] r_pending;
    logic [15:0]       r_stallCount;

    logic              w_readsReg1;
    logic              w_readsReg2;
    logic              w_writesDest;
    logic [REGNUM-1:0] w_wbMask;
    logic [REGNUM-1:0] w_destMask;
    logic [REGNUM-1:0] w_effPending;
    logic              w_hazard;
    logic              w_issue;
    logic              w_stall;

    // Opcode classification and hazard detection against the bypassed scoreboard
    always_comb begin
        w_readsReg1  = (opcode != OP_NOP);
        w_readsReg2  = (opcode != OP_NOP) && (opcode < OP_IMM);
        w_writesDest = (opcode != OP_NOP) && (opcode != OP_STORE);
        w_wbMask     = wbValid ? (REGNUM'(1) << wbAddress) : '0;
        w_destMask   = REGNUM'(1) << regDestinationAddress;
        w_effPending = r_pending & ~w_wbMask;
        w_hazard     = (w_readsReg1  && w_effPending[reg1Address])
                     | (w_readsReg2  && w_effPending[reg2Address])
                     | (w_writesDest && w_effPending[regDestinationAddress]);
        // startIO blocks issue in the very cycle it is seen in RUN
        w_issue      = decValid && (r_state == ST_RUN) && !startIO && !w_hazard;
        w_stall      = decValid && !w_issue;
    end

    // Scoreboard: writeback clears, issue sets; set wins on the same bit
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_effPending | ((w_issue && w_writesDest) ? w_destMask : '0);
        end
    end

    // IO ownership sequencing: RUN -> DRAIN -> IO -> RUN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   if (startIO) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_effPending == '0) r_state <= ST_IO;
                ST_IO:    if (ioDone) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    // Saturating count of cycles in which a valid instruction was held back
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != 16'hFFFF)) begin
            r_stallCount <= r_stallCount + 16'd1;
        end
    end

    assign issue      = w_issue;
    assign stall      = w_stall;
    assign ioGrant    = (r_state == ST_IO);
    assign stallCount = r_stallCount;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Self-checking bench for decode_hazard_ctrl: a stimulus table with expected
// outputs routed through a scoreboard queue, then hand-written sequences for
// reset during IO and stall-counter saturation.
module tb_decode_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        decValid;
    logic [3:0]  opcode;
    logic [3:0]  reg1Address;
    logic [3:0]  reg2Address;
    logic [3:0]  regDestinationAddress;
    logic        wbValid;
    logic [3:0]  wbAddress;
    logic        startIO;
    logic        ioDone;
    logic        issue;
    logic        stall;
    logic        ioGrant;
    logic [15:0] stallCount;

    always #5 clock = ~clock;

    decode_hazard_ctrl #(
        .ADDRESSWIDTH(4),
        .REGNUM(16),
        .OPCODEWIDTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .decValid(decValid),
        .opcode(opcode),
        .reg1Address(reg1Address),
        .reg2Address(reg2Address),
        .regDestinationAddress(regDestinationAddress),
        .wbValid(wbValid),
        .wbAddress(wbAddress),
        .startIO(startIO),
        .ioDone(ioDone),
        .issue(issue),
        .stall(stall),
        .ioGrant(ioGrant),
        .stallCount(stallCount)
    );

    typedef struct {
        logic       dv;
        logic [3:0] op, r1, r2, rd;
        logic       wbv;
        logic [3:0] wba;
        logic       sio, idn;
        logic       e_iss, e_stl, e_gnt;
    } vec_t;

    typedef struct {
        string       name;
        logic        iss, stl, gnt;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] model_cnt = '0;
    vec_t        tbl[25];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic vec_t V(input logic dv, input logic [3:0] op, input logic [3:0] r1,
                               input logic [3:0] r2, input logic [3:0] rd, input logic wbv,
                               input logic [3:0] wba, input logic sio, input logic idn,
                               input logic ei, input logic es, input logic eg);
        vec_t v;
        v.dv = dv; v.op = op; v.r1 = r1; v.r2 = r2; v.rd = rd;
        v.wbv = wbv; v.wba = wba; v.sio = sio; v.idn = idn;
        v.e_iss = ei; v.e_stl = es; v.e_gnt = eg;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        decValid = v.dv; opcode = v.op; reg1Address = v.r1; reg2Address = v.r2;
        regDestinationAddress = v.rd; wbValid = v.wbv; wbAddress = v.wba;
        startIO = v.sio; ioDone = v.idn;
    endtask

    task automatic push_exp(input string n, input vec_t v);
        exp_t e;
        e.name = n; e.iss = v.e_iss; e.stl = v.e_stl; e.gnt = v.e_gnt; e.cnt = model_cnt;
        sbq.push_back(e);
        if (v.e_stl && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    endtask

    task automatic sample_check();
        exp_t e;
        if (sbq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard: got empty queue required one entry");
        end else begin
            e = sbq.pop_front();
            chk({e.name, ".issue"},      {15'd0, issue},   {15'd0, e.iss});
            chk({e.name, ".stall"},      {15'd0, stall},   {15'd0, e.stl});
            chk({e.name, ".ioGrant"},    {15'd0, ioGrant}, {15'd0, e.gnt});
            chk({e.name, ".stallCount"}, stallCount,       e.cnt);
        end
    endtask

    task automatic run_vec(input string n, input vec_t v);
        drive(v);
        push_exp(n, v);
        @(negedge clock);
        sample_check();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //          dv  op     r1  r2  rd  wbv wba sio idn  iss stl gnt
        tbl[0]  = V(1, 4'h1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0); // produce r3
        tbl[1]  = V(1, 4'h2, 3, 0, 6, 0, 0, 0, 0, 0, 1, 0); // RAW on r3
        tbl[2]  = V(1, 4'h2, 3, 0, 6, 0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = V(1, 4'h2, 3, 0, 6, 1, 3, 0, 0, 1, 0, 0); // wb bypass
        tbl[4]  = V(1, 4'h9, 2, 6, 7, 0, 0, 0, 0, 1, 0, 0); // reg2 ignored
        tbl[5]  = V(1, 4'hE, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0); // store, no WAW
        tbl[6]  = V(1, 4'h9, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0); // r6 still pending
        tbl[7]  = V(1, 4'h1, 0, 7, 2, 0, 0, 0, 0, 0, 1, 0); // reg2 RAW
        tbl[8]  = V(1, 4'hF, 7, 7, 7, 0, 0, 0, 0, 1, 0, 0); // NOP
        tbl[9]  = V(1, 4'h3, 0, 0, 7, 0, 0, 0, 0, 0, 1, 0); // WAW
        tbl[10] = V(1, 4'h3, 0, 0, 7, 1, 7, 0, 0, 1, 0, 0); // set wins
        tbl[11] = V(1, 4'h9, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0); // r7 still pending
        tbl[12] = V(0, 4'h0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
        tbl[13] = V(0, 4'h0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        tbl[14] = V(1, 4'h1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0); // produce r1
        tbl[15] = V(1, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0); // startIO blocks issue
        tbl[16] = V(1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); // DRAIN holds
        tbl[17] = V(0, 4'h0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0); // drained by wb
        tbl[18] = V(1, 4'hF, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1); // IO, startIO ignored
        tbl[19] = V(0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1); // ioDone
        tbl[20] = V(1, 4'hF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0); // back in RUN
        tbl[21] = V(0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); // ioDone ignored
        tbl[22] = V(0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0); // startIO, nothing pending
        tbl[23] = V(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // DRAIN one cycle
        tbl[24] = V(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); // IO

        // Reset state, including issue following decValid while in reset
        reset = 1'b1;
        drive(V(0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("rst.ioGrant",    {15'd0, ioGrant}, 16'd0);
        chk("rst.stallCount", stallCount,       16'd0);
        chk("rst.issue_idle", {15'd0, issue},   16'd0);
        decValid = 1'b1; opcode = 4'hF;
        #1;
        chk("rst.issue_dv",   {15'd0, issue},   16'd1);
        chk("rst.stall_dv",   {15'd0, stall},   16'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 25; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset while in IO: grant and counter drop without waiting for a clock
        chk("io.grant_before", {15'd0, ioGrant}, 16'd1);
        reset = 1'b1;
        #1;
        chk("io.rst_grant", {15'd0, ioGrant}, 16'd0);
        chk("io.rst_count", stallCount,       16'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_cnt = '0;

        // Hold a RAW hazard long enough to saturate the counter
        run_vec("sat.produce", V(1, 4'h1, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
        drive(V(1, 4'h2, 3, 0, 6, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 65534; i++) @(posedge clock);
        #1;
        chk("sat.fffe",  stallCount,       16'hFFFE);
        chk("sat.stall", {15'd0, stall},   16'd1);
        for (int i = 0; i < 4466; i++) @(posedge clock);
        #1;
        chk("sat.ffff",  stallCount,       16'hFFFF);
        wbValid = 1'b1; wbAddress = 4'd3;
        #1;
        chk("sat.wb_issue", {15'd0, issue}, 16'd1);
        @(posedge clock);
        #1;
        chk("sat.hold", stallCount, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
